// File: rtl/hue_sweep_gen.sv
// hue_sweep_gen: prescaled 8-bit hue sweeper with wrap, bounce and hold modes
module hue_sweep_gen #(
  parameter int TICK_DIV = 1_000_000,
  parameter int HUE_MAX  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [3:0] step,
  input  logic       load,
  input  logic [7:0] load_hue,
  output logic [7:0] h,
  output logic       h_valid,
  output logic       dir,
  output logic       wrap_pulse
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [8:0] HMAX = 9'(HUE_MAX);
  logic [CW-1:0] cnt;
  logic          tick;
  logic [8:0]    h9, s9, up;
  logic [7:0]    nh;
  logic          nd, nw;
  assign tick = en && cnt == LAST;
  assign h9   = {1'b0, h};
  assign s9   = {5'b0, step};
  assign up   = h9 + s9;
  // Bounce tests run in 9 bits so h+step never overflows before the compare
  always_comb begin
    nh = h;
    nd = dir;
    nw = 1'b0;
    if (mode == 2'b01) begin
      nh = up[7:0];
      nd = 1'b1;
      nw = up[8];
    end else if (mode == 2'b10) begin
      if (h9 > HMAX || (dir && up >= HMAX)) begin
        nh = HMAX[7:0];
        nd = 1'b0;
        nw = 1'b1;
      end else if (dir) nh = up[7:0];
      else if (h9 <= s9) begin
        nh = 8'd0;
        nd = 1'b1;
        nw = 1'b1;
      end else nh = 8'(h9 - s9);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      h          <= 8'd0;
      dir        <= 1'b1;
      h_valid    <= 1'b0;
      wrap_pulse <= 1'b0;
    end else if (load) begin
      cnt        <= '0;
      h          <= load_hue;
      h_valid    <= 1'b1;
      wrap_pulse <= 1'b0;
    end else begin
      h_valid    <= 1'b0;
      wrap_pulse <= 1'b0;
      if (en) cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        h          <= nh;
        dir        <= nd;
        h_valid    <= nh != h;
        wrap_pulse <= nw;
      end
    end
  end
endmodule
